// File: rtl/edge_event_pkg.sv
// Shared edge-mode encodings and default geometry for the edge event unit.
package edge_event_pkg;

    localparam logic [1:0] MODE_OFF  = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_FALL = 2'b10;
    localparam logic [1:0] MODE_BOTH = 2'b11;

    localparam int DEF_CHANNELS    = 4;
    localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/edge_event_channel.sv
// One input channel: synchroniser, optional debounce (EDGE_EVENT_DEBOUNCE_EN),
// mode-selected edge pulse and sticky pending flag.
module edge_event_channel
    import edge_event_pkg::*;
#(
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_din,
    input  logic [1:0] i_mode,
    input  logic       i_clr,
    input  logic       i_priming,
    output logic       o_pulse,
    output logic       o_level,
    output logic       o_pending
);

    if (SYNC_STAGES < 2 || DEBOUNCE_CYCLES < 1 ||
        (DEBOUNCE_CYCLES - 1) >= (1 << CNT_W)) begin : g_cfg_check
        $error("edge_event_channel: invalid SYNC_STAGES/DEBOUNCE_CYCLES/CNT_W");
    end

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync;
    logic                   w_filt;
    logic                   r_filt_d;
    logic                   r_pulse;
    logic                   r_pending;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_edge;
    logic                   w_pulse_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_din};
        end
    end

    assign w_sync = r_sync[SYNC_STAGES-1];

`ifdef EDGE_EVENT_DEBOUNCE_EN
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] r_cnt;
    logic             r_filt;

    // Filtered level only moves after DEBOUNCE_CYCLES consecutive disagreeing samples.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_filt <= 1'b0;
        end else if (i_priming) begin
            r_cnt  <= '0;
            r_filt <= w_sync;
        end else if (w_sync == r_filt) begin
            r_cnt  <= '0;
        end else if (r_cnt == CNT_LAST) begin
            r_cnt  <= '0;
            r_filt <= w_sync;
        end else begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    assign w_filt = r_filt;
`else
    assign w_filt = w_sync;
`endif

    assign w_rise = w_filt & ~r_filt_d;
    assign w_fall = ~w_filt & r_filt_d;

    always_comb begin
        w_edge = 1'b0;
        case (i_mode)
            MODE_RISE: w_edge = w_rise;
            MODE_FALL: w_edge = w_fall;
            MODE_BOTH: w_edge = w_rise | w_fall;
            default:   w_edge = 1'b0;
        endcase
    end

    assign w_pulse_next = w_edge & ~i_priming;

    // While priming, the history flop tracks the sync output so a level
    // present at reset release never looks like an edge afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_d  <= 1'b0;
            r_pulse   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_filt_d  <= i_priming ? w_sync : w_filt;
            r_pulse   <= w_pulse_next;
            r_pending <= w_pulse_next | (r_pending & ~i_clr);
        end
    end

    assign o_pulse   = r_pulse;
    assign o_level   = w_filt;
    assign o_pending = r_pending;

endmodule

// File: rtl/edge_event_unit.sv
// Multi-channel edge event unit: per-channel sync/debounce/edge detection,
// shared post-reset priming counter and registered irq. Debounce is built
// only when EDGE_EVENT_DEBOUNCE_EN is defined.
module edge_event_unit
    import edge_event_pkg::*;
#(
    parameter int CHANNELS        = DEF_CHANNELS,
    parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [CHANNELS-1:0]   din,
    input  logic [2*CHANNELS-1:0] mode,
    input  logic [CHANNELS-1:0]   clr,
    output logic [CHANNELS-1:0]   pulse,
    output logic [CHANNELS-1:0]   level,
    output logic [CHANNELS-1:0]   pending,
    output logic                  irq
);

    localparam int                 PRIME_W    = $clog2(SYNC_STAGES + 2);
    localparam logic [PRIME_W-1:0] PRIME_LAST = PRIME_W'(SYNC_STAGES + 1);

    logic [PRIME_W-1:0] r_prime;
    logic               w_priming;
    logic               r_irq;

    assign w_priming = (r_prime != PRIME_LAST);

    // Counts the SYNC_STAGES+1 cycles after reset release, then parks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prime <= '0;
        end else if (w_priming) begin
            r_prime <= r_prime + 1'b1;
        end
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        edge_event_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .CNT_W           (CNT_W)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_din     (din[gi]),
            .i_mode    (mode[2*gi +: 2]),
            .i_clr     (clr[gi]),
            .i_priming (w_priming),
            .o_pulse   (pulse[gi]),
            .o_level   (level[gi]),
            .o_pending (pending[gi])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= |pending;
        end
    end

    assign irq = r_irq;

endmodule
